// File: rtl/i2c_passthru_mst_engine.sv
// Byte-level I2C/SMBus initiator on one open-drain channel.
// START / repeated START / WRITE / READ / STOP from a single-command handshake.
module i2c_passthru_mst_engine #(
    parameter int F_REF_T_LOW          = 38,
    parameter int F_REF_T_SU_DAT       = 2,
    parameter int F_REF_T_HI           = 511,
    parameter int WIDTH_F_REF_T_LOW    = 6,
    parameter int WIDTH_F_REF_T_SU_DAT = 2,
    parameter int WIDTH_F_REF_T_HI     = 9
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_f_ref,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wdata,
    input  logic       i_rd_nack,
    output logic       o_rsp_valid,
    output logic [7:0] o_rdata,
    output logic       o_ack,
    output logic       o_arb_lost,
    output logic       o_timeout,
    output logic       o_err,
    output logic       o_bus_owned
);

    // One shared tick counter; wide enough for T_SU_DAT+T_LOW and T_HI.
    localparam int W_LS = (WIDTH_F_REF_T_LOW > WIDTH_F_REF_T_SU_DAT) ?
                          WIDTH_F_REF_T_LOW : WIDTH_F_REF_T_SU_DAT;
    localparam int CW   = (W_LS + 1 > WIDTH_F_REF_T_HI) ?
                          W_LS + 1 : WIDTH_F_REF_T_HI;

    localparam logic [CW-1:0] C_LOW = CW'(F_REF_T_LOW);
    localparam logic [CW-1:0] C_SU  = CW'(F_REF_T_SU_DAT);
    localparam logic [CW-1:0] C_STO = CW'(F_REF_T_SU_DAT + F_REF_T_LOW);
    localparam logic [CW-1:0] C_HI  = CW'(F_REF_T_HI);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        STA_SU,
        STA_HD,
        BIT_LOW,
        BIT_SU,
        BIT_RISE,
        BIT_HIGH,
        STO_LOW,
        STO_RISE,
        STO_SU,
        STO_BUF,
        RSP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ref_q, ref_d;
    logic          tick_q, tick_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          owned_q, owned_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    sh_q, sh_d;
    logic          nack_q, nack_d;
    logic [3:0]    bitn_q, bitn_d;
    logic          samp_q, samp_d;
    logic          first_q, first_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          arb_q, arb_d;
    logic          to_q, to_d;
    logic          err_q, err_d;

    logic          go_rsp;
    logic          r_ack;
    logic          r_arb;
    logic          r_to;
    logic          r_err;
    logic [7:0]    r_rdata;
    logic          arb_hit;

    assign o_scl       = scl_q;
    assign o_sda       = sda_q;
    assign o_cmd_ready = (state_q == IDLE) || (state_q == RSP);
    assign o_rsp_valid = (state_q == RSP);
    assign o_rdata     = rdata_q;
    assign o_ack       = ack_q;
    assign o_arb_lost  = arb_q;
    assign o_timeout   = to_q;
    assign o_err       = err_q;
    assign o_bus_owned = owned_q;

    // Only a WRITE data bit we released can lose arbitration.
    assign arb_hit = first_q && (cmd_q == CMD_WRITE) && (bitn_q != 4'd8)
                     && sda_q && !i_sda;

    // Next-state, line drive and response capture.
    always_comb begin
        state_d = state_q;
        ref_d   = i_f_ref;
        tick_d  = i_f_ref & ~ref_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        owned_d = owned_q;
        cmd_d   = cmd_q;
        sh_d    = sh_q;
        nack_d  = nack_q;
        bitn_d  = bitn_q;
        samp_d  = samp_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        arb_d   = arb_q;
        to_d    = to_q;
        err_d   = err_q;
        go_rsp  = 1'b0;
        r_ack   = 1'b0;
        r_arb   = 1'b0;
        r_to    = 1'b0;
        r_err   = 1'b0;
        r_rdata = 8'h00;

        unique case (state_q)
            IDLE, RSP: begin
                if (state_q == RSP) state_d = IDLE;
                if (i_cmd_valid) begin
                    cmd_d  = i_cmd;
                    sh_d   = i_wdata;
                    nack_d = i_rd_nack;
                    bitn_d = 4'd0;
                    unique case (i_cmd)
                        CMD_START: begin
                            if (owned_q) begin
                                sda_d   = 1'b1;
                                state_d = BIT_LOW;
                            end else if (i_scl && i_sda) begin
                                sda_d   = 1'b0;
                                state_d = STA_HD;
                            end else begin
                                go_rsp = 1'b1;
                                r_arb  = 1'b1;
                            end
                        end
                        CMD_STOP: begin
                            if (owned_q) begin
                                sda_d   = 1'b0;
                                state_d = STO_LOW;
                            end else begin
                                go_rsp = 1'b1;
                                r_err  = 1'b1;
                            end
                        end
                        default: begin
                            if (owned_q) begin
                                state_d = BIT_LOW;
                            end else begin
                                go_rsp = 1'b1;
                                r_err  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            STA_SU: begin
                if (cnt_q == C_LOW) begin
                    sda_d   = 1'b0;
                    state_d = STA_HD;
                end
            end
            STA_HD: begin
                if (cnt_q == C_LOW) begin
                    scl_d   = 1'b0;
                    owned_d = 1'b1;
                    go_rsp  = 1'b1;
                end
            end
            BIT_LOW: begin
                scl_d = 1'b0;
                if (cmd_q == CMD_START) begin
                    if (cnt_q == C_LOW) begin
                        scl_d   = 1'b1;
                        state_d = BIT_RISE;
                    end
                end else if (cnt_q == C_SU) begin
                    state_d = BIT_SU;
                    if (bitn_q == 4'd8) begin
                        // ACK slot: WRITE listens, READ releases for NACK.
                        sda_d = (cmd_q == CMD_WRITE) ? 1'b1 : nack_q;
                    end else begin
                        sda_d = (cmd_q == CMD_WRITE) ? sh_q[7] : 1'b1;
                    end
                end
            end
            BIT_SU: begin
                if (cnt_q == C_LOW) begin
                    scl_d   = 1'b1;
                    state_d = BIT_RISE;
                end
            end
            BIT_RISE, STO_RISE: begin
                if (i_scl) begin
                    if (state_q == STO_RISE)      state_d = STO_SU;
                    else if (cmd_q == CMD_START)  state_d = STA_SU;
                    else                          state_d = BIT_HIGH;
                end else if (cnt_q == C_HI) begin
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    owned_d = 1'b0;
                    go_rsp  = 1'b1;
                    r_to    = 1'b1;
                end
            end
            BIT_HIGH: begin
                if (arb_hit) begin
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    owned_d = 1'b0;
                    go_rsp  = 1'b1;
                    r_arb   = 1'b1;
                end else begin
                    if (first_q) begin
                        samp_d = i_sda;
                        if (bitn_q != 4'd8) sh_d = {sh_q[6:0], i_sda};
                    end
                    if (cnt_q == C_LOW) begin
                        scl_d = 1'b0;
                        if (bitn_q == 4'd8) begin
                            sda_d   = 1'b1;
                            go_rsp  = 1'b1;
                            r_ack   = (cmd_q == CMD_WRITE) & ~samp_q;
                            r_rdata = (cmd_q == CMD_READ) ? sh_q : 8'h00;
                        end else begin
                            bitn_d  = bitn_q + 4'd1;
                            state_d = BIT_LOW;
                        end
                    end
                end
            end
            STO_LOW: begin
                if (cnt_q == C_STO) begin
                    scl_d   = 1'b1;
                    state_d = STO_RISE;
                end
            end
            STO_SU: begin
                if (cnt_q == C_LOW) begin
                    sda_d   = 1'b1;
                    state_d = STO_BUF;
                end
            end
            STO_BUF: begin
                if (cnt_q == C_LOW) begin
                    owned_d = 1'b0;
                    go_rsp  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_rsp) begin
            state_d = RSP;
            ack_d   = r_ack;
            arb_d   = r_arb;
            to_d    = r_to;
            err_d   = r_err;
            rdata_d = r_rdata;
        end

        first_d = (state_d == BIT_HIGH) && (state_q != BIT_HIGH);

        if (state_q == IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, tick_q};
        end
    end

    // State, counters and response registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ref_q   <= 1'b0;
            tick_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            owned_q <= 1'b0;
            cmd_q   <= 2'b00;
            sh_q    <= 8'h00;
            nack_q  <= 1'b0;
            bitn_q  <= 4'd0;
            samp_q  <= 1'b1;
            first_q <= 1'b0;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
            arb_q   <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            tick_q  <= tick_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            owned_q <= owned_d;
            cmd_q   <= cmd_d;
            sh_q    <= sh_d;
            nack_q  <= nack_d;
            bitn_q  <= bitn_d;
            samp_q  <= samp_d;
            first_q <= first_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            arb_q   <= arb_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

endmodule
